// File: rtl/datapath_seq_nreg.sv
// Sequenced N-register bus datapath: one start runs Y-load, ALU and writeback.
// Optional signed multiplier on opcode 11 when DATAPATH_MUL_EN is defined.
module datapath_seq_nreg #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 16,
  localparam int RIDX_W   = $clog2(NUM_REGS),
  localparam int SH_W     = $clog2(DATA_W)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        opcode,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic [RIDX_W-1:0] rc,
  input  logic              ld_en,
  input  logic [RIDX_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RIDX_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] z_hi,
  output logic [DATA_W-1:0] z_lo
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHRA = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [2:0] {
    IDLE, YLD, ALU, WB, DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   y;
  logic [2*DATA_W-1:0] z;
  logic [3:0]          cap_op;
  logic [RIDX_W-1:0]   cap_ra;
  logic [RIDX_W-1:0]   cap_rb;
  logic [RIDX_W-1:0]   cap_rc;

  logic [DATA_W-1:0]   bus;
  logic [2*DATA_W-1:0] alu_z;
  logic                alu_bad;
  logic [SH_W-1:0]     sh;
  logic [DATA_W:0]     add_w;
  logic [DATA_W:0]     sub_w;
  logic [DATA_W-1:0]   sra_w;
  logic [DATA_W-1:0]   neg_w;
  logic [2*DATA_W-1:0] rol_w;
  logic [DATA_W-1:0]   zero_w;

  assign rd_data = regs[rd_addr];
  assign z_hi    = z[2*DATA_W-1:DATA_W];
  assign z_lo    = z[DATA_W-1:0];

  always_comb begin
    bus = '0;
    case (state)
      YLD:     bus = regs[cap_rb];
      ALU:     bus = regs[cap_rc];
      WB:      bus = z[DATA_W-1:0];
      default: bus = '0;
    endcase
  end

  assign sh     = bus[SH_W-1:0];
  assign zero_w = '0;
  assign add_w  = {1'b0, y} + {1'b0, bus};
  assign sub_w  = {1'b0, y} - {1'b0, bus};
  assign sra_w  = $signed(y) >>> sh;
  assign neg_w  = zero_w - bus;
  // Rotate via a doubled word: the upper half after the shift is the result.
  assign rol_w  = {y, y} << sh;

`ifdef DATAPATH_MUL_EN
  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed({{DATA_W{y[DATA_W-1]}}, y})
              * $signed({{DATA_W{bus[DATA_W-1]}}, bus});
`endif

  always_comb begin
    alu_z   = '0;
    alu_bad = 1'b0;
    case (cap_op)
      OP_ADD:  alu_z = {{(DATA_W-1){1'b0}}, add_w};
      OP_SUB:  alu_z = {{DATA_W{sub_w[DATA_W]}},
                        sub_w[DATA_W-1:0]};
      OP_AND:  alu_z = {zero_w, y & bus};
      OP_OR:   alu_z = {zero_w, y | bus};
      OP_XOR:  alu_z = {zero_w, y ^ bus};
      OP_SHL:  alu_z = {zero_w, y << sh};
      OP_SHR:  alu_z = {zero_w, y >> sh};
      OP_SHRA: alu_z = {zero_w, sra_w};
      OP_ROL:  alu_z = {zero_w, rol_w[2*DATA_W-1:DATA_W]};
      OP_NOT:  alu_z = {zero_w, ~bus};
      OP_NEG:  alu_z = {zero_w, neg_w};
`ifdef DATAPATH_MUL_EN
      OP_MUL:  alu_z = prod;
`else
      OP_MUL:  alu_bad = 1'b1;
`endif
      default: alu_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = YLD;
      YLD: begin
        busy       = 1'b1;
        state_next = ALU;
      end
      ALU: begin
        busy       = 1'b1;
        state_next = WB;
      end
      WB: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      y       <= '0;
      z       <= '0;
      cap_op  <= '0;
      cap_ra  <= '0;
      cap_rb  <= '0;
      cap_rc  <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          // Preload lands at the accept edge, so YLD sees it.
          if (ld_en) regs[ld_addr] <= ld_data;
          if (start) begin
            cap_op  <= opcode;
            cap_ra  <= ra;
            cap_rb  <= rb;
            cap_rc  <= rc;
            illegal <= 1'b0;
          end
        end
        YLD: y <= bus;
        ALU: begin
          z       <= alu_z;
          illegal <= alu_bad;
        end
        WB: if (!illegal) regs[cap_ra] <= bus;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_seq_nreg.sv
// Randomized bench for datapath_seq_nreg against an arithmetic reference model.
// Honours DATAPATH_MUL_EN the same way the design does.
module tb_datapath_seq_nreg;

  localparam int DW = 32;
  localparam int NR = 16;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    opcode = '0;
  logic [3:0]    ra = '0, rb = '0, rc = '0;
  logic          ld_en = 1'b0;
  logic [3:0]    ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [3:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy, done, illegal;
  logic [DW-1:0] z_hi, z_lo;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] mregs [NR];

  datapath_seq_nreg #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .illegal(illegal),
    .z_hi(z_hi), .z_lo(z_lo)
  );

  always #5 clock = ~clock;

  function automatic void model(input logic [3:0] op,
                                input logic [DW-1:0] a,
                                input logic [DW-1:0] b,
                                output logic [2*DW-1:0] zz,
                                output logic bad);
    logic [DW-1:0] r;
    int amt;
    longint p;
    amt = int'(b % 32);
    bad = 1'b0;
    r   = '0;
    zz  = '0;
    case (op)
      4'd0: zz = {32'h0, a} + {32'h0, b};
      4'd1: begin
        r  = a - b;
        zz = {(a < b) ? 32'hFFFF_FFFF : 32'h0, r};
      end
      4'd2: zz = {32'h0, a & b};
      4'd3: zz = {32'h0, a | b};
      4'd4: zz = {32'h0, a ^ b};
      4'd5: begin r = a << amt; zz = {32'h0, r}; end
      4'd6: begin r = a >> amt; zz = {32'h0, r}; end
      4'd7: begin
        r = a >> amt;
        if (a[31] && amt != 0) r = r | ~(32'hFFFF_FFFF >> amt);
        zz = {32'h0, r};
      end
      4'd8: begin
        r = (amt == 0) ? a : ((a << amt) | (a >> (32 - amt)));
        zz = {32'h0, r};
      end
      4'd9:  zz = {32'h0, ~b};
      4'd10: begin r = 32'h0 - b; zz = {32'h0, r}; end
`ifdef DATAPATH_MUL_EN
      4'd11: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        zz = p;
      end
`endif
      default: bad = 1'b1;
    endcase
  endfunction

  task automatic preload(input logic [3:0] idx, input logic [DW-1:0] val);
    ld_en = 1'b1; ld_addr = idx; ld_data = val;
    @(posedge clock); #1;
    ld_en = 1'b0;
    mregs[idx] = val;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c,
                        input bit with_ld, input logic [3:0] li,
                        input logic [DW-1:0] lv);
    logic [2*DW-1:0] ez;
    logic ebad;
    int cyc;
    opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
    if (with_ld) begin
      ld_en = 1'b1; ld_addr = li; ld_data = lv;
      mregs[li] = lv;
    end
    model(op, mregs[b], mregs[c], ez, ebad);
    @(posedge clock); #1;
    start = 1'b0; ld_en = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept op=%0d got=%b want=1", op, busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      @(posedge clock); #1; cyc++;
    end
    vectors++;
    if (cyc != 3 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_latency op=%0d got=%0d want=3", op, cyc);
    end
    vectors++;
    if (illegal !== ebad) begin
      miscompares++;
      $display("FAIL illegal op=%0d got=%b want=%b", op, illegal, ebad);
    end
    if (!ebad) begin
      mregs[a] = ez[DW-1:0];
      vectors++;
      if ({z_hi, z_lo} !== ez) begin
        miscompares++;
        $display("FAIL z op=%0d got=%h_%h want=%h", op, z_hi, z_lo, ez);
      end
    end
    rd_addr = a; #1;
    vectors++;
    if (rd_data !== mregs[a]) begin
      miscompares++;
      $display("FAIL rd_dest op=%0d r%0d got=%h want=%h",
               op, a, rd_data, mregs[a]);
    end
    @(posedge clock); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || illegal !== ebad) begin
      miscompares++;
      $display("FAIL post_done op=%0d got=%b%b%b want=00%b",
               op, done, busy, illegal, ebad);
    end
  endtask

  task automatic check_reg(input logic [3:0] idx, input logic [DW-1:0] want,
                           input string name);
    rd_addr = idx; #1;
    vectors++;
    if (rd_data !== want || mregs[idx] !== want) begin
      miscompares++;
      $display("FAIL %s r%0d got=%h model=%h want=%h",
               name, idx, rd_data, mregs[idx], want);
    end
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < NR; i++) begin
      rd_addr = 4'(i); #1;
      vectors++;
      if (rd_data !== mregs[i]) begin
        miscompares++;
        $display("FAIL %s r%0d got=%h want=%h", name, i, rd_data, mregs[i]);
      end
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    for (int i = 0; i < NR; i++) mregs[i] = '0;
  endtask

  task automatic test_reset();
    do_clear();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 ||
        z_hi !== '0 || z_lo !== '0) begin
      miscompares++;
      $display("FAIL reset_outs got=%b%b%b %h %h want=000 0 0",
               busy, done, illegal, z_hi, z_lo);
    end
    check_all("reset_regs");
  endtask

  task automatic test_directed();
    preload(4'd2, 32'h0000_0022);
    preload(4'd6, 32'h0000_0024);
    run_op(4'd2, 4'd5, 4'd2, 4'd6, 0, 4'd0, '0);
    check_reg(4'd5, 32'h0000_0020, "and_r5");
    preload(4'd1, 32'hFFFF_FFFF);
    preload(4'd3, 32'h0000_0001);
    run_op(4'd0, 4'd4, 4'd1, 4'd3, 0, 4'd0, '0);
    check_reg(4'd4, 32'h0, "add_r4");
    run_op(4'd1, 4'd4, 4'd3, 4'd1, 0, 4'd0, '0);
    check_reg(4'd4, 32'h2, "sub_r4");
    preload(4'd7, 32'h8000_0001);
    preload(4'd8, 32'h0000_0021);
    run_op(4'd7, 4'd12, 4'd7, 4'd8, 0, 4'd0, '0);
    check_reg(4'd12, 32'hC000_0000, "shra");
    run_op(4'd8, 4'd12, 4'd7, 4'd8, 0, 4'd0, '0);
    check_reg(4'd12, 32'h0000_0003, "rol");
    preload(4'd8, 32'h0000_0020);
    run_op(4'd5, 4'd12, 4'd7, 4'd8, 0, 4'd0, '0);
    check_reg(4'd12, 32'h8000_0001, "shl_zero");
    preload(4'd9, 32'hFFFF_FFFD);
    preload(4'd10, 32'h0000_0007);
    preload(4'd11, 32'h1234_5678);
    run_op(4'd11, 4'd11, 4'd9, 4'd10, 0, 4'd0, '0);
`ifdef DATAPATH_MUL_EN
    check_reg(4'd11, 32'hFFFF_FFEB, "mul_r11");
`else
    check_reg(4'd11, 32'h1234_5678, "mul_illegal_r11");
`endif
    preload(4'd3, 32'h5);
    run_op(4'd0, 4'd3, 4'd3, 4'd3, 0, 4'd0, '0);
    check_reg(4'd3, 32'd10, "add_self");
    run_op(4'd0, 4'd3, 4'd3, 4'd3, 1, 4'd3, 32'h1);
    check_reg(4'd3, 32'd2, "ld_start_same");
    run_op(4'd14, 4'd3, 4'd3, 4'd3, 0, 4'd0, '0);
    check_reg(4'd3, 32'd2, "op14_illegal");
  endtask

  task automatic test_ignore_busy();
    logic [2*DW-1:0] ez;
    logic ebad;
    int cyc;
    int extra;
    preload(4'd9, 32'hAAAA_0000);
    model(4'd3, mregs[1], mregs[2], ez, ebad);
    opcode = 4'd3; ra = 4'd13; rb = 4'd1; rc = 4'd2; start = 1'b1;
    @(posedge clock); #1;
    opcode = 4'd10; ra = 4'd9;
    ld_en = 1'b1; ld_addr = 4'd9; ld_data = 32'h5555_5555;
    @(posedge clock); #1;
    start = 1'b0; ld_en = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 10) begin
      @(posedge clock); #1; cyc++;
    end
    mregs[13] = ez[DW-1:0];
    vectors++;
    if (cyc != 3) begin
      miscompares++;
      $display("FAIL busy_ignore_latency got=%0d want=3", cyc);
    end
    check_reg(4'd9, 32'hAAAA_0000, "ld_dropped");
    check_reg(4'd13, ez[DW-1:0], "busy_ignore_result");
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (busy === 1'b1 || done === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL start_ignored got=%0d busy_cycles want=0", extra);
    end
  endtask

  task automatic test_clear_midop();
    int seen;
    opcode = 4'd0; ra = 4'd4; rb = 4'd4; rc = 4'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    do_clear();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(posedge clock); #1;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL clear_midop got=%0d active_cycles want=0", seen);
    end
    check_all("clear_regs");
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] e1, e2;
    logic b1, b2;
    int d1, d2, cyc;
    preload(4'd1, 32'h0000_00F0);
    preload(4'd2, 32'h0000_000F);
    model(4'd3, mregs[1], mregs[2], e1, b1);
    model(4'd4, e1[DW-1:0], mregs[2], e2, b2);
    opcode = 4'd3; ra = 4'd5; rb = 4'd1; rc = 4'd2; start = 1'b1;
    @(posedge clock); #1;
    opcode = 4'd4; ra = 4'd6; rb = 4'd5; rc = 4'd2;
    d1 = -1; d2 = -1; cyc = 0;
    while (d2 < 0 && cyc < 20) begin
      @(posedge clock); #1; cyc++;
      if (done === 1'b1 && d1 < 0) d1 = cyc;
      else if (done === 1'b1) begin d2 = cyc; start = 1'b0; end
    end
    start = 1'b0;
    mregs[5] = e1[DW-1:0];
    mregs[6] = e2[DW-1:0];
    vectors++;
    if (d1 != 3 || d2 != 8) begin
      miscompares++;
      $display("FAIL b2b_timing got=%0d,%0d want=3,8", d1, d2);
    end
    check_reg(4'd5, e1[DW-1:0], "b2b_first");
    check_reg(4'd6, e2[DW-1:0], "b2b_second");
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      preload(4'($urandom_range(0, 15)), $urandom);
      preload(4'($urandom_range(0, 15)), $urandom);
      run_op(4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0),
             4'($urandom_range(0, 15)), $urandom);
    end
    check_all("random_regs");
  endtask

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_clear_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
